// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, instruction fields, FSM states and ALU ops for the 8-bit CPU
package cpu_pkg;
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_LDI  = 4'h6;
  localparam logic [3:0] OP_MOV  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_BEQZ = 4'h9;
  localparam logic [3:0] OP_HLT  = 4'hF;
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 9;
  localparam int RS1_MSB = 8;
  localparam int RS1_LSB = 6;
  localparam int RS2_MSB = 5;
  localparam int RS2_LSB = 3;
  localparam int IMM_MSB = 7;
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK, S_HALT} state_t;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_PASS} alu_op_t;
  function automatic alu_op_t alu_op_of(input logic [3:0] opc);
    return opc == OP_ADD ? ALU_ADD :
           opc == OP_SUB ? ALU_SUB :
           opc == OP_AND ? ALU_AND :
           opc == OP_OR  ? ALU_OR  :
           opc == OP_XOR ? ALU_XOR : ALU_PASS;
  endfunction
endpackage

// File: rtl/alu8.sv
// alu8: combinational 8-bit ALU with carry/borrow and zero outputs
module alu8
  import cpu_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  alu_op_t    op,
  output logic [7:0] y,
  output logic       carry,
  output logic       zero
);
  logic [8:0] r;
  always_comb begin
    r = op == ALU_ADD ? {1'b0, a} + {1'b0, b} :
        op == ALU_SUB ? {1'b0, a} - {1'b0, b} :
        op == ALU_AND ? {1'b0, a & b} :
        op == ALU_OR  ? {1'b0, a | b} :
        op == ALU_XOR ? {1'b0, a ^ b} : {1'b0, a};
  end
  assign y = r[7:0];
  assign carry = r[8];
  assign zero = r[7:0] == 8'd0;
endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: four-cycle fetch/decode/execute/writeback controller with ALU and Z/C flags
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  output logic [7:0]  instr_addr,
  input  logic [15:0] instr_data,
  output logic [2:0]  rf_rd_addr1,
  output logic [2:0]  rf_rd_addr2,
  input  logic [7:0]  rf_rd_data1,
  input  logic [7:0]  rf_rd_data2,
  output logic        rf_write_en,
  output logic [2:0]  rf_wr_addr,
  output logic [7:0]  rf_wr_data,
  output logic        zero_flag,
  output logic        carry_flag,
  output logic        illegal_op,
  output logic        halted
);
  state_t state, state_n;
  logic [15:0] ir;
  logic [7:0] pc, a, b, imm, alu_a, alu_y, pc_n;
  logic [3:0] opc;
  logic alu_c, alu_z, flag_op, wr_op;
  assign opc = ir[OPC_MSB:OPC_LSB];
  assign imm = ir[IMM_MSB:0];
  assign flag_op = opc >= OP_ADD && opc <= OP_XOR;
  assign wr_op = opc >= OP_ADD && opc <= OP_MOV;
  assign alu_a = opc == OP_LDI ? imm : a;
  alu8 u_alu (.a(alu_a), .b(b), .op(alu_op_of(opc)), .y(alu_y), .carry(alu_c), .zero(alu_z));
  always_comb begin
    pc_n = opc == OP_JMP || (opc == OP_BEQZ && a == 8'd0) ? imm : pc + 8'd1;
    state_n = state == S_FETCH     ? S_DECODE :
              state == S_DECODE    ? S_EXECUTE :
              state == S_EXECUTE   ? S_WRITEBACK :
              state == S_WRITEBACK ? (opc == OP_HLT ? S_HALT : S_FETCH) : S_HALT;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_FETCH;
      pc <= RESET_PC;
      ir <= '0;
      a <= '0;
      b <= '0;
      rf_wr_addr <= '0;
      rf_wr_data <= '0;
      zero_flag <= 1'b0;
      carry_flag <= 1'b0;
    end else begin
      state <= state_n;
      if (state == S_FETCH) ir <= instr_data;
      if (state == S_DECODE) begin
        a <= rf_rd_data1;
        b <= rf_rd_data2;
      end
      if (state == S_EXECUTE) begin
        rf_wr_data <= alu_y;
        rf_wr_addr <= ir[RD_MSB:RD_LSB];
        if (flag_op) begin
          zero_flag <= alu_z;
          carry_flag <= alu_c;
        end
      end
      if (state == S_WRITEBACK) pc <= pc_n;
    end
  end
  // Write enable is decoded from state so a reset in WRITEBACK drops it at once
  assign rf_write_en = state == S_WRITEBACK && wr_op;
  assign illegal_op = state == S_DECODE && opc >= 4'hA && opc <= 4'hE;
  assign halted = state == S_HALT;
  assign instr_addr = pc;
  assign rf_rd_addr1 = ir[RS1_MSB:RS1_LSB];
  assign rf_rd_addr2 = ir[RS2_MSB:RS2_LSB];
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed program run against a ROM and register-file model
module tb_cpu_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] instr_addr, rf_rd_data1, rf_rd_data2, rf_wr_data;
  logic [15:0] instr_data;
  logic [2:0] rf_rd_addr1, rf_rd_addr2, rf_wr_addr;
  logic rf_write_en, zero_flag, carry_flag, illegal_op, halted;
  logic [15:0] rom [256];
  logic [7:0] rf [8];
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] instr;
    logic        we;
    logic [2:0]  wa;
    logic [7:0]  wd;
    logic        z;
    logic        c;
    logic        ill;
  } vec_t;
  vec_t v [13];

  cpu_sequencer #(.RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst), .instr_addr(instr_addr), .instr_data(instr_data),
    .rf_rd_addr1(rf_rd_addr1), .rf_rd_addr2(rf_rd_addr2),
    .rf_rd_data1(rf_rd_data1), .rf_rd_data2(rf_rd_data2),
    .rf_write_en(rf_write_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .zero_flag(zero_flag), .carry_flag(carry_flag), .illegal_op(illegal_op), .halted(halted)
  );

  always #5 clk = ~clk;
  assign instr_data = rom[instr_addr];
  assign rf_rd_data1 = rf[rf_rd_addr1];
  assign rf_rd_data2 = rf[rf_rd_addr2];
  always @(posedge clk) if (rf_write_en) rf[rf_wr_addr] <= rf_wr_data;

  function automatic logic [15:0] enc_r(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1, input logic [2:0] rs2);
    return {op, rd, rs1, rs2, 3'b000};
  endfunction

  function automatic logic [15:0] enc_i(input logic [3:0] op, input logic [2:0] rd, input logic b8, input logic [7:0] imm);
    return {op, rd, b8, imm};
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " instr_addr"}, instr_addr, 8'h00);
    chk({tag, " rd_addr1"}, rf_rd_addr1, 3'd0);
    chk({tag, " rd_addr2"}, rf_rd_addr2, 3'd0);
    chk({tag, " write_en"}, rf_write_en, 1'b0);
    chk({tag, " wr_addr"}, rf_wr_addr, 3'd0);
    chk({tag, " wr_data"}, rf_wr_data, 8'h00);
    chk({tag, " zero"}, zero_flag, 1'b0);
    chk({tag, " carry"}, carry_flag, 1'b0);
    chk({tag, " illegal"}, illegal_op, 1'b0);
    chk({tag, " halted"}, halted, 1'b0);
  endtask

  // Entered mid-FETCH; leaves mid-FETCH of the following instruction
  task automatic run_instr(input vec_t e, input int idx);
    string t;
    t = $sformatf("i%0d", idx);
    chk({t, " fetch addr"}, instr_addr, e.addr);
    chk({t, " fetch we"}, rf_write_en, 1'b0);
    step();
    chk({t, " decode illegal"}, illegal_op, e.ill);
    chk({t, " decode we"}, rf_write_en, 1'b0);
    step();
    chk({t, " exec illegal"}, illegal_op, 1'b0);
    chk({t, " exec we"}, rf_write_en, 1'b0);
    step();
    chk({t, " wb we"}, rf_write_en, e.we);
    if (e.we) begin
      chk({t, " wb addr"}, rf_wr_addr, e.wa);
      chk({t, " wb data"}, rf_wr_data, e.wd);
    end
    chk({t, " zero"}, zero_flag, e.z);
    chk({t, " carry"}, carry_flag, e.c);
    chk({t, " wb halted"}, halted, 1'b0);
    step();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    for (int i = 0; i < 8; i++) rf[i] = 8'h00;
    v[0]  = '{8'h00, enc_i(4'h6, 3'd1, 1'b0, 8'hF0), 1'b1, 3'd1, 8'hF0, 1'b0, 1'b0, 1'b0};
    v[1]  = '{8'h01, enc_i(4'h6, 3'd2, 1'b0, 8'h20), 1'b1, 3'd2, 8'h20, 1'b0, 1'b0, 1'b0};
    v[2]  = '{8'h02, enc_r(4'h1, 3'd3, 3'd1, 3'd2),  1'b1, 3'd3, 8'h10, 1'b0, 1'b1, 1'b0};
    v[3]  = '{8'h03, enc_r(4'h2, 3'd5, 3'd2, 3'd1),  1'b1, 3'd5, 8'h30, 1'b0, 1'b1, 1'b0};
    v[4]  = '{8'h04, 16'hB000,                       1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b1};
    v[5]  = '{8'h05, enc_i(4'h9, 3'd0, 1'b1, 8'h40), 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0};
    v[6]  = '{8'h06, enc_r(4'h2, 3'd4, 3'd1, 3'd1),  1'b1, 3'd4, 8'h00, 1'b1, 1'b0, 1'b0};
    v[7]  = '{8'h07, enc_r(4'h2, 3'd5, 3'd1, 3'd1),  1'b1, 3'd5, 8'h00, 1'b1, 1'b0, 1'b0};
    v[8]  = '{8'h08, enc_i(4'h9, 3'd0, 1'b1, 8'h40), 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0};
    v[9]  = '{8'h40, enc_r(4'h7, 3'd6, 3'd3, 3'd0),  1'b1, 3'd6, 8'h10, 1'b1, 1'b0, 1'b0};
    v[10] = '{8'h41, enc_i(4'h8, 3'd0, 1'b0, 8'hFF), 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0};
    v[11] = '{8'hFF, 16'h0000,                       1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0};
    v[12] = '{8'h00, enc_i(4'h6, 3'd1, 1'b0, 8'hF0), 1'b1, 3'd1, 8'hF0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 13; i++) rom[v[i].addr] = v[i].instr;
    step();
    check_reset("por");
    rst = 1'b0;
    #1;
    for (int i = 0; i < 13; i++) run_instr(v[i], i);
    chk("rf R3", rf[3], 8'h10);
    chk("rf R6", rf[6], 8'h10);
    // Reset mid-EXECUTE of LDI R2 at 0x01
    step();
    step();
    rst = 1'b1;
    #1;
    check_reset("rst exec");
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post-rst fetch addr", instr_addr, 8'h00);
    // Reset during WRITEBACK must suppress the write
    rom[0] = enc_i(4'h6, 3'd7, 1'b0, 8'h55);
    rom[1] = 16'hF000;
    step();
    step();
    step();
    chk("wb before rst we", rf_write_en, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst in wb we", rf_write_en, 1'b0);
    @(posedge clk);
    #1;
    chk("rst in wb R7 kept", rf[7], 8'h00);
    @(negedge clk);
    rst = 1'b0;
    #1;
    run_instr('{8'h00, rom[0], 1'b1, 3'd7, 8'h55, 1'b0, 1'b0, 1'b0}, 20);
    chk("R7 written", rf[7], 8'h55);
    run_instr('{8'h01, 16'hF000, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0}, 21);
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("halt%0d halted", i), halted, 1'b1);
      chk($sformatf("halt%0d addr", i), instr_addr, 8'h02);
      chk($sformatf("halt%0d we", i), rf_write_en, 1'b0);
      step();
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("resume halted", halted, 1'b0);
    run_instr('{8'h00, rom[0], 1'b1, 3'd7, 8'h55, 1'b0, 1'b0, 1'b0}, 22);
    chk("resume fetch addr", instr_addr, 8'h01);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
